// File: rtl/usb3_tx_arbiter.sv
// rtl/usb3_tx_arbiter.sv - packet-atomic 3-port TX arbiter feeding the scrambler/SKP stage
// Optional: define USB3_TXARB_RR_EN to alternate ports 1 and 2 under contention (port 0 stays highest).
module usb3_tx_arbiter #(
  parameter int GAP_WORDS = 1,
  parameter int MAX_WORDS = 280
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        link_en,
  input  logic [2:0]  req_valid,
  input  logic [95:0] req_data,
  input  logic [11:0] req_datak,
  input  logic [2:0]  req_last,
  output logic [2:0]  req_ready,
  output logic [31:0] raw_data,
  output logic [3:0]  raw_datak,
  output logic        raw_active,
  input  logic        raw_stall,
  output logic        skp_defer,
  output logic [1:0]  grant,
  output logic        err_underrun,
  output logic        err_overlength
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [1:0] NO_GRANT = 2'd3;
  // Gap reload saturates into the 4-bit counter; at least one idle word always follows a packet.
  localparam logic [3:0] GAP_LOAD = (GAP_WORDS > 15) ? 4'd15 :
                                    (GAP_WORDS < 1)  ? 4'd1  : 4'(GAP_WORDS);
  localparam logic [8:0] MAX_CNT  = 9'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] raw_data_q, raw_data_d;
  logic [3:0]  raw_datak_q, raw_datak_d;
  logic        raw_active_q, raw_active_d;
  logic        skp_defer_q, skp_defer_d;
  logic        err_underrun_q, err_underrun_d;
  logic        err_overlength_q, err_overlength_d;

  logic        own_valid;
  logic        own_last;
  logic [31:0] own_data;
  logic [3:0]  own_datak;
  logic [1:0]  win;
  logic        start_pkt;

`ifdef USB3_TXARB_RR_EN
  logic        last2_q, last2_d;
`endif

  // A new packet may start only from IDLE, with the link up and no SKP slot being taken.
  assign start_pkt = (state_q == ST_IDLE) && link_en && !raw_stall && (|req_valid);

  // Select the request signals of the current owner.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    own_datak = '0;
    case (grant_q)
      2'd0: begin
        own_valid = req_valid[0];
        own_last  = req_last[0];
        own_data  = req_data[31:0];
        own_datak = req_datak[3:0];
      end
      2'd1: begin
        own_valid = req_valid[1];
        own_last  = req_last[1];
        own_data  = req_data[63:32];
        own_datak = req_datak[7:4];
      end
      2'd2: begin
        own_valid = req_valid[2];
        own_last  = req_last[2];
        own_data  = req_data[95:64];
        own_datak = req_datak[11:8];
      end
      default: begin
      end
    endcase
  end

  // Ready goes only to the owner while a packet is in flight and the link is up.
  always_comb begin
    req_ready = 3'b000;
    if (link_en && (state_q == ST_PKT)) begin
      case (grant_q)
        2'd0:    req_ready = 3'b001;
        2'd1:    req_ready = 3'b010;
        2'd2:    req_ready = 3'b100;
        default: req_ready = 3'b000;
      endcase
    end
  end

  // Pick the winner among valid requesters.
  always_comb begin
    win = NO_GRANT;
    if (req_valid[0]) begin
      win = 2'd0;
`ifdef USB3_TXARB_RR_EN
    end else if (req_valid[1] && req_valid[2]) begin
      win = last2_q ? 2'd1 : 2'd2;
`endif
    end else if (req_valid[1]) begin
      win = 2'd1;
    end else if (req_valid[2]) begin
      win = 2'd2;
    end
  end

`ifdef USB3_TXARB_RR_EN
  // Remember whether port 2 (1) or port 1 (0) was granted most recently.
  always_comb begin
    last2_d = last2_q;
    if (start_pkt && (win == 2'd1)) begin
      last2_d = 1'b0;
    end else if (start_pkt && (win == 2'd2)) begin
      last2_d = 1'b1;
    end
  end

  // Last-served flag register; starts as if port 2 went last so port 1 wins first.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      last2_q <= 1'b1;
    end else begin
      last2_q <= last2_d;
    end
  end
`endif

  // Next state, counters and the registered symbol word.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    word_cnt_d       = word_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    raw_data_d       = '0;
    raw_datak_d      = '0;
    raw_active_d     = 1'b0;
    err_underrun_d   = 1'b0;
    err_overlength_d = 1'b0;
    skp_defer_d      = (|req_valid) || (state_q == ST_PKT);

    if (!link_en) begin
      state_d    = ST_IDLE;
      grant_d    = NO_GRANT;
      word_cnt_d = '0;
      gap_cnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          grant_d    = NO_GRANT;
          word_cnt_d = '0;
          gap_cnt_d  = '0;
          if (start_pkt) begin
            grant_d = win;
            state_d = ST_PKT;
          end
        end
        ST_PKT: begin
          if (!own_valid) begin
            // Source starved mid-packet: hold the packet open with a zero word.
            raw_active_d   = 1'b1;
            err_underrun_d = 1'b1;
          end else if ((word_cnt_q == MAX_CNT) && !own_last) begin
            // Overlength word is dropped and the packet is cut short.
            err_overlength_d = 1'b1;
            state_d          = ST_GAP;
            grant_d          = NO_GRANT;
            word_cnt_d       = '0;
            gap_cnt_d        = GAP_LOAD;
          end else begin
            raw_data_d   = own_data;
            raw_datak_d  = own_datak;
            raw_active_d = 1'b1;
            word_cnt_d   = word_cnt_q + 9'd1;
            if (own_last) begin
              state_d    = ST_GAP;
              grant_d    = NO_GRANT;
              word_cnt_d = '0;
              gap_cnt_d  = GAP_LOAD;
            end
          end
        end
        ST_GAP: begin
          grant_d   = NO_GRANT;
          gap_cnt_d = (gap_cnt_q == 4'd0) ? 4'd0 : gap_cnt_q - 4'd1;
          if (gap_cnt_q <= 4'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          grant_d = NO_GRANT;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      grant_q          <= NO_GRANT;
      word_cnt_q       <= '0;
      gap_cnt_q        <= '0;
      raw_data_q       <= '0;
      raw_datak_q      <= '0;
      raw_active_q     <= 1'b0;
      skp_defer_q      <= 1'b0;
      err_underrun_q   <= 1'b0;
      err_overlength_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      word_cnt_q       <= word_cnt_d;
      gap_cnt_q        <= gap_cnt_d;
      raw_data_q       <= raw_data_d;
      raw_datak_q      <= raw_datak_d;
      raw_active_q     <= raw_active_d;
      skp_defer_q      <= skp_defer_d;
      err_underrun_q   <= err_underrun_d;
      err_overlength_q <= err_overlength_d;
    end
  end

  assign raw_data       = raw_data_q;
  assign raw_datak      = raw_datak_q;
  assign raw_active     = raw_active_q;
  assign skp_defer      = skp_defer_q;
  assign grant          = grant_q;
  assign err_underrun   = err_underrun_q;
  assign err_overlength = err_overlength_q;

endmodule

// File: doc/usb3_tx_arbiter.md
# usb3_tx_arbiter

Packet-atomic transmit arbiter and sequencer that sits directly upstream of the TX scrambler / SKP-insertion stage. It shares the single 32-bit TX symbol path between three link-layer sources:
- port 0: link commands;
- port 1: header packets;
- port 2: data payloads.

It holds `raw_active` high for the whole of each packet so SKP ordered sets are only inserted between packets. Between packets it emits logical-idle words and enforces a minimum inter-packet gap.

## Interface
Parameters:
- `GAP_WORDS`, 1: minimum idle words emitted after every packet (range 1–15).
- `MAX_WORDS`, 280: packet length limit in words; the word that would exceed it triggers an abort.

Ports:
- `local_clk`  in  1  TX symbol clock.
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `link_en`  in  1  link allowed to transmit; low forces IDLE.
- `req_valid`  in  3  per-port word valid.
- `req_data`  in  96  per-port data; port n occupies [32n+31:32n].
- `req_datak`  in  12  per-port K flags; port n occupies [4n+3:4n].
- `req_last`  in  3  per-port last-word-of-packet flag.
- `req_ready`  out  3  per-port word accept.
- `raw_data`  out  32  symbol word to scrambler.
- `raw_datak`  out  4  K flags to scrambler.
- `raw_active`  out  1  packet in progress; SKP insertion blocked.
- `raw_stall`  in  1  scrambler consumed an idle slot for SKP.
- `skp_defer`  out  1  a request is pending or granted.
- `grant`  out  2  current owner: 0–2, or 3 when none.
- `err_underrun`  out  1  one-cycle pulse: granted port not valid mid-packet.
- `err_overlength`  out  1  one-cycle pulse: packet aborted at `MAX_WORDS`.

## Operation
- States are IDLE, PKT and GAP.
- All outputs are registered except `req_ready`, which is decoded from registered state.
- Reset values:
  - `raw_data`=0, `raw_datak`=0, `raw_active`=0;
  - `grant`=3, `skp_defer`=0, both error outputs 0;
  - state IDLE, word counter 0, gap counter 0.
- IDLE:
  - Emits the idle word (data 0, datak 0, active 0).
  - If `link_en` is high, `raw_stall` is low and any `req_valid` is high, it latches the winner into `grant` and moves to PKT.
  - Priority is fixed 0 > 1 > 2, unless the round-robin feature is compiled in (see Configuration).
  - With `raw_stall` high, no grant is made that cycle.
- PKT:
  - `req_ready[grant]`=1; all other ready bits are 0.
  - On `valid&ready`: `raw_data` and `raw_datak` take the port word, `raw_active`=1, and the 9-bit word counter increments.
  - On an accepted word with `req_last`: go to GAP and load the gap counter with `GAP_WORDS`.
  - If `req_valid[grant]` is low, emit data 0, datak 0 with `raw_active`=1, pulse `err_underrun` and stay in PKT.
  - If the accepted word is number `MAX_WORDS`+1 (counter equals `MAX_WORDS`) and it is not last:
    - the word is dropped, not forwarded;
    - emit the idle word with `raw_active`=0 and pulse `err_overlength`;
    - go to GAP.
    - The source must then flush itself; the arbiter does not drain it.
- GAP:
  - Emits the idle word with active 0; `grant`=3; the gap counter decrements.
  - At 1 it returns to IDLE.
  - Counter reload and decrement are saturating, 4 bits wide.
- `link_en` low, in any state: next state IDLE, `grant`=3, counters cleared, idle word emitted, no ready. A packet in flight is truncated without an error pulse.
- `skp_defer` = any `req_valid` OR state PKT.
- `raw_stall` is ignored outside IDLE.

## Timing
- From `req_valid` rising in IDLE to the first word on `raw_data`: 2 cycles.
  - Edge 1: grant registered.
  - Cycle 1: ready high.
  - Edge 2: word registered onto `raw_data`.
- Throughput in PKT is one word per cycle.
- From the last word to the next grant: `GAP_WORDS`+1 cycles, i.e. GAP plus the IDLE decision.
- An asynchronous reset mid-packet clears all outputs immediately. The source sees `req_ready` drop in the same cycle.

## Configuration
- `USB3_TXARB_RR_EN` defined:
  - Port 0 keeps absolute priority.
  - Ports 1 and 2 alternate: a 1-bit last-served flag updates on each grant to port 1 or 2.
  - When both are valid and port 0 is not, the port not served last wins.
- Undefined: fixed priority 0 > 1 > 2, and the flag logic is absent.

## Test plan
- Port 1 sends a 5-word packet (`0x11110000`…`0x11110004`, last on word 5) with `GAP_WORDS`=1:
  - words appear on `raw_data` 2 cycles after valid, with `raw_active`=1 for exactly 5 cycles;
  - then one idle word with active 0;
  - `grant` goes 3 → 1 → 3.
- Ports 0, 1 and 2 are all valid simultaneously, each with a 1-word packet:
  - service order is 0, 1, 2, with 2 idle cycles between packets (gap + IDLE);
  - with `USB3_TXARB_RR_EN` and repeated 1/2 contention, the order is 1, 2, 1, 2.
- `raw_stall`=1 in the IDLE cycle in which port 2 becomes valid: grant is deferred one cycle and the first word is delayed to cycle 3.
- Port 2 drops valid for 2 cycles mid-packet:
  - 2 words of 0 with `raw_active`=1;
  - `err_underrun` pulses twice;
  - the packet then resumes intact.
- A port 2 packet of 281 words with `MAX_WORDS`=280:
  - 280 words are forwarded;
  - the 281st is not forwarded; `err_overlength` pulses and `raw_active` drops in the same cycle;
  - the arbiter then passes through GAP back to IDLE.
- `reset_n` asserted mid-packet: `raw_*`=0, `grant`=3 and `req_ready`=0 asynchronously; after release, a new request is granted normally.
